mc_control_fsm: RTL

- Multicycle MIPS control unit. It sits directly upstream of the datapath Register instances (PC, IR, A/B, ALUOut, MDR) and the register file.
- It generates the WE strobes and mux selects that decide when each Register captures its Data input.
- It sequences each instruction through fetch, decode, execute, memory and writeback states, driven by the IR opcode and the ALU Zero flag.

---
 rtl/mc_control_fsm.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS control unit.
// Sequences each instruction through fetch/decode/execute/memory/writeback
// and drives the datapath register write enables and mux selects.
// Optional build macro MC_MEM_WAIT_EN adds a MemReady input that stretches
// MEMRD/MEMWR until memory signals completion.
module mc_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [5:0]  Opcode,
    input  logic        Zero,
`ifdef MC_MEM_WAIT_EN
    input  logic        MemReady,
`endif
    output logic        PC_WE,
    output logic        IR_WE,
    output logic        AB_WE,
    output logic        ALUOUT_WE,
    output logic        MDR_WE,
    output logic        RF_WE,
    output logic        MEM_WE,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  PCSrc,
    output logic        RegDst,
    output logic        MemToReg,
    output logic        IllegalOp,
    output logic [31:0] InstrCnt
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_illegal;
    logic        w_mem_ready;

    logic        r_pc_we;
    logic        r_branch;
    logic        r_ir_we;
    logic        r_ab_we;
    logic        r_aluout_we;
    logic        r_mdr_we;
    logic        r_rf_we;
    logic        r_mem_we;
    logic        r_alusrca;
    logic [1:0]  r_alusrcb;
    logic [1:0]  r_aluop;
    logic [1:0]  r_pcsrc;
    logic        r_regdst;
    logic        r_memtoreg;
    logic        r_illegal;
    logic [31:0] r_cnt;

`ifdef MC_MEM_WAIT_EN
    assign w_mem_ready = MemReady;
`else
    assign w_mem_ready = 1'b1;
`endif

    // Next-state selection from the current state, Opcode and memory handshake.
    always_comb begin
        w_next    = S_IDLE;
        w_illegal = 1'b0;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                if (Opcode == OP_LW || Opcode == OP_SW) w_next = S_MEMADR;
                else if (Opcode == OP_RTYPE)            w_next = S_EXEC;
                else if (Opcode == OP_BEQ)              w_next = S_BRANCH;
                else if (Opcode == OP_ADDI)             w_next = S_ADDIEX;
                else if (Opcode == OP_J)                w_next = S_JUMP;
                else begin
                    w_next    = S_FETCH;
                    w_illegal = 1'b1;
                end
            end
            S_MEMADR: w_next = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = w_mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = w_mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_ADDIEX: w_next = S_ADDIWB;
            S_ADDIWB: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    // State register; outputs are registered from the next state so they
    // present exactly the Moore decode of the state being entered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_pc_we     <= 1'b0;
            r_branch    <= 1'b0;
            r_ir_we     <= 1'b0;
            r_ab_we     <= 1'b0;
            r_aluout_we <= 1'b0;
            r_mdr_we    <= 1'b0;
            r_rf_we     <= 1'b0;
            r_mem_we    <= 1'b0;
            r_alusrca   <= 1'b0;
            r_alusrcb   <= '0;
            r_aluop     <= '0;
            r_pcsrc     <= '0;
            r_regdst    <= 1'b0;
            r_memtoreg  <= 1'b0;
            r_illegal   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_next;
            r_pc_we     <= 1'b0;
            r_branch    <= 1'b0;
            r_ir_we     <= 1'b0;
            r_ab_we     <= 1'b0;
            r_aluout_we <= 1'b0;
            r_mdr_we    <= 1'b0;
            r_rf_we     <= 1'b0;
            r_mem_we    <= 1'b0;
            r_alusrca   <= 1'b0;
            r_alusrcb   <= 2'b00;
            r_aluop     <= 2'b00;
            r_pcsrc     <= 2'b00;
            r_regdst    <= 1'b0;
            r_memtoreg  <= 1'b0;
            case (w_next)
                S_FETCH: begin
                    r_ir_we   <= 1'b1;
                    r_pc_we   <= 1'b1;
                    r_alusrcb <= 2'b01;
                end
                S_DECODE: begin
                    r_ab_we     <= 1'b1;
                    r_aluout_we <= 1'b1;
                    r_alusrcb   <= 2'b11;
                end
                S_MEMADR, S_ADDIEX: begin
                    r_alusrca   <= 1'b1;
                    r_alusrcb   <= 2'b10;
                    r_aluout_we <= 1'b1;
                end
                S_MEMRD: r_mdr_we <= 1'b1;
                S_MEMWB: begin
                    r_rf_we    <= 1'b1;
                    r_memtoreg <= 1'b1;
                end
                S_MEMWR: r_mem_we <= 1'b1;
                S_EXEC: begin
                    r_alusrca   <= 1'b1;
                    r_aluop     <= 2'b10;
                    r_aluout_we <= 1'b1;
                end
                S_ALUWB: begin
                    r_rf_we  <= 1'b1;
                    r_regdst <= 1'b1;
                end
                S_BRANCH: begin
                    r_alusrca <= 1'b1;
                    r_aluop   <= 2'b01;
                    r_pcsrc   <= 2'b01;
                    r_branch  <= 1'b1;
                end
                S_ADDIWB: r_rf_we <= 1'b1;
                S_JUMP: begin
                    r_pcsrc <= 2'b10;
                    r_pc_we <= 1'b1;
                end
                default: ;
            endcase
            if (w_illegal)
                r_illegal <= 1'b1;
            if (w_next == S_FETCH && r_state != S_IDLE && !w_illegal)
                r_cnt <= r_cnt + 32'd1;
        end
    end

    // BRANCH is the one state whose PC write follows the live Zero flag.
    assign PC_WE     = r_pc_we | (r_branch & Zero);
    assign IR_WE     = r_ir_we;
    assign AB_WE     = r_ab_we;
    assign ALUOUT_WE = r_aluout_we;
    assign MDR_WE    = r_mdr_we;
    assign RF_WE     = r_rf_we;
    assign MEM_WE    = r_mem_we;
    assign ALUSrcA   = r_alusrca;
    assign ALUSrcB   = r_alusrcb;
    assign ALUOp     = r_aluop;
    assign PCSrc     = r_pcsrc;
    assign RegDst    = r_regdst;
    assign MemToReg  = r_memtoreg;
    assign IllegalOp = r_illegal;
    assign InstrCnt  = r_cnt;

endmodule
